// File: rtl/spectro_pkg.sv
// Shared spectrogram datapath definitions: Q1.17 widths, product scaling and saturation.
// Used by the phasor NCO and the DFT bin accumulator.
package spectro_pkg;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned FRAC   = 17;
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StSq0,
    StSq1,
    StSq2
  } dft_state_e;

  // Drops p[34]; floors toward -inf, and -1.0 * -1.0 wraps to 0.
  function automatic logic signed [DATA_W-1:0] scale_prod(input logic signed [PROD_W-1:0] p);
    return {p[PROD_W-1], p[PROD_W-3:FRAC]};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [31:0] x);
    if (x > 32'sd131071) begin
      return 18'sh1FFFF;
    end else if (x < -32'sd131072) begin
      return 18'sh20000;
    end else begin
      return x[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dft_bin_accum_if.sv
// Sample/phasor input bundle and bin-power result bundle for dft_bin_accum.
interface dft_bin_accum_if;
  import spectro_pkg::*;

  logic                     start;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] cos0;
  logic signed [DATA_W-1:0] sin0;
  logic signed [DATA_W-1:0] cos1;
  logic signed [DATA_W-1:0] sin1;
  logic                     busy;
  logic                     out_valid;
  logic [PROD_W-1:0]        pow0;
  logic [PROD_W-1:0]        pow1;

  modport master (
    output start, sample_valid, sample, cos0, sin0, cos1, sin1,
    input  busy, out_valid, pow0, pow1
  );

  modport slave (
    input  start, sample_valid, sample, cos0, sin0, cos1, sin1,
    output busy, out_valid, pow0, pow1
  );

endinterface

// File: rtl/dft_mac_lane.sv
// One complex MAC lane: registers s*cos and s*sin (stage 1), then accumulates
// re += s*cos, im -= s*sin (stage 2).
module dft_mac_lane
  import spectro_pkg::*;
#(
  parameter int unsigned AccW = 25
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic signed [DATA_W-1:0] cos_i,
  input  logic signed [DATA_W-1:0] sin_i,
  output logic signed [AccW-1:0]   re_o,
  output logic signed [AccW-1:0]   im_o
);

  logic signed [PROD_W-1:0] p_re, p_im;
  logic signed [DATA_W-1:0] prod_re_q, prod_im_q;
  logic                     prod_vld_q;
  logic signed [AccW-1:0]   re_q, im_q;

  assign p_re = sample_i * cos_i;
  assign p_im = sample_i * sin_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      prod_re_q  <= '0;
      prod_im_q  <= '0;
      prod_vld_q <= 1'b0;
      re_q       <= '0;
      im_q       <= '0;
    end else begin
      prod_vld_q <= en_i;
      if (en_i) begin
        prod_re_q <= scale_prod(p_re);
        prod_im_q <= scale_prod(p_im);
      end
      if (prod_vld_q) begin
        re_q <= re_q + AccW'(prod_re_q);
        im_q <= im_q - AccW'(prod_im_q);
      end
    end
  end

  assign re_o = re_q;
  assign im_o = im_q;

endmodule

// File: rtl/dft_bin_accum.sv
// Two-bin DFT accumulator: complex MAC over an N-sample frame, then |X|^2 per bin
// through one shared pair of squaring multipliers.
module dft_bin_accum
  import spectro_pkg::*;
#(
  parameter int unsigned N = 128
) (
  input  logic            CK,
  input  logic            RST,
  dft_bin_accum_if.slave  bus
);

  localparam int unsigned Log2N = $clog2(N);
  localparam int unsigned AccW  = DATA_W + Log2N;
  localparam int unsigned CntW  = Log2N + 1;

  dft_state_e state_q, state_d;

  logic [CntW-1:0]          count_q;
  logic                     accept, last;
  logic signed [AccW-1:0]   re0, im0, re1, im1;
  logic signed [AccW-1:0]   re_sel, im_sel, re_sh, im_sh;
  logic signed [DATA_W-1:0] re_sat, im_sat;
  logic signed [PROD_W-1:0] sq_re, sq_im;
  logic [PROD_W-1:0]        sq_re_q, sq_im_q, sq_sum;
  logic [PROD_W-1:0]        pow0_hold_q, pow0_q, pow1_q;
  logic                     busy_q, out_valid_q;

  // START always wins, including over the Nth sample.
  assign accept = (state_q == StAccum) && bus.sample_valid && !bus.start;
  assign last   = accept && (count_q == CntW'(N - 1));

  dft_mac_lane #(.AccW(AccW)) u_lane0 (
    .clk_i    (CK),
    .rst_i    (RST),
    .clr_i    (bus.start),
    .en_i     (accept),
    .sample_i (bus.sample),
    .cos_i    (bus.cos0),
    .sin_i    (bus.sin0),
    .re_o     (re0),
    .im_o     (im0)
  );

  dft_mac_lane #(.AccW(AccW)) u_lane1 (
    .clk_i    (CK),
    .rst_i    (RST),
    .clr_i    (bus.start),
    .en_i     (accept),
    .sample_i (bus.sample),
    .cos_i    (bus.cos1),
    .sin_i    (bus.sin1),
    .re_o     (re1),
    .im_o     (im1)
  );

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = StAccum;
    end else begin
      case (state_q)
        StIdle:  state_d = StIdle;
        StAccum: if (last) state_d = StDrain;
        StDrain: state_d = StSq0;
        StSq0:   state_d = StSq1;
        StSq1:   state_d = StSq2;
        StSq2:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Shared squarers: bin 0 in SQ0, bin 1 in SQ1.
  always_comb begin
    re_sel = (state_q == StSq1) ? re1 : re0;
    im_sel = (state_q == StSq1) ? im1 : im0;
    re_sh  = re_sel >>> Log2N;
    im_sh  = im_sel >>> Log2N;
    re_sat = sat_data(32'(re_sh));
    im_sat = sat_data(32'(im_sh));
  end

  assign sq_re  = re_sat * re_sat;
  assign sq_im  = im_sat * im_sat;
  assign sq_sum = sq_re_q + sq_im_q;

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= StIdle;
      count_q     <= '0;
      sq_re_q     <= '0;
      sq_im_q     <= '0;
      pow0_hold_q <= '0;
      pow0_q      <= '0;
      pow1_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (bus.start) begin
        count_q <= '0;
      end else if (accept) begin
        count_q <= count_q + CntW'(1);
      end

      if ((state_q == StSq0) || (state_q == StSq1)) begin
        sq_re_q <= sq_re;
        sq_im_q <= sq_im;
      end
      // pow0 is staged so both outputs change together with out_valid.
      if (state_q == StSq1) begin
        pow0_hold_q <= sq_sum;
      end
      if ((state_q == StSq2) && !bus.start) begin
        pow0_q <= pow0_hold_q;
        pow1_q <= sq_sum;
      end

      if (bus.start) begin
        busy_q <= 1'b1;
      end else if (state_q == StSq2) begin
        busy_q <= 1'b0;
      end
      out_valid_q <= (state_q == StSq2) && !bus.start;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pow0      = pow0_q;
  assign bus.pow1      = pow1_q;

endmodule

// File: tb/tb_dft_bin_accum.sv
// Self-checking bench for dft_bin_accum: directed frames plus random phasor data
// checked against an arithmetic model of the frame DFT power.
module tb_dft_bin_accum;
  import spectro_pkg::*;

  localparam int unsigned N = 128;

  logic CK = 1'b0;
  logic RST = 1'b1;
  always #5 CK = ~CK;

  dft_bin_accum_if bus ();

  dft_bin_accum #(.N(N)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ov_seen = 0;
  int cyc_start = 0;
  int cyc_done = 0;
  longint m_re0, m_im0, m_re1, m_im1;

  always @(posedge CK) cyc <= cyc + 1;
  always @(negedge CK) if (bus.out_valid === 1'b1) ov_seen <= ov_seen + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  function automatic longint floor_div(input longint x, input longint d);
    longint q;
    q = x / d;
    if (x < 0 && q * d != x) q = q - 1;
    return q;
  endfunction

  // Q1.17 product, floored; only -1.0 * -1.0 reaches +1.0, which wraps to 0.
  function automatic longint scaled(input longint a, input longint b);
    longint q;
    q = floor_div(a * b, 131072);
    if (q == 131072) q = 0;
    return q;
  endfunction

  function automatic longint clamp18(input longint x);
    if (x > 131071) return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  function automatic longint bin_pow(input longint re, input longint im);
    longint r, i;
    r = clamp18(floor_div(re, N));
    i = clamp18(floor_div(im, N));
    return r * r + i * i;
  endfunction

  function automatic int rnd18();
    return int'($urandom_range(262143)) - 131072;
  endfunction

  task automatic drive(input int s, input int c0, input int s0, input int c1, input int s1);
    bus.sample = DATA_W'(s);
    bus.cos0   = DATA_W'(c0);
    bus.sin0   = DATA_W'(s0);
    bus.cos1   = DATA_W'(c1);
    bus.sin1   = DATA_W'(s1);
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc_start = cyc;
    m_re0 = 0; m_im0 = 0; m_re1 = 0; m_im1 = 0;
    check("busy_after_start", 64'(bus.busy), 64'(1));
    for (int k = 0; k < 5; k++) begin
      drive(rnd18(), rnd18(), rnd18(), rnd18(), rnd18());
      step();
    end
  endtask

  // mode 0/1/2: directed lanes from the frame cases; others random.
  task automatic pick(input int mode, output int s, output int c0, output int s0,
                      output int c1, output int s1);
    s = rnd18(); c0 = rnd18(); s0 = rnd18(); c1 = rnd18(); s1 = rnd18();
    case (mode)
      0: begin s = 65536;   c0 = 131071; s0 = 0;      end
      1: begin s = -65536;  c0 = 0;      s0 = 131071; end
      2: begin s = 131071;  c1 = 131071; s1 = 0;      end
      default: ;
    endcase
  endtask

  task automatic feed(input int mode, input int cnt, input int gap_pct, output int gaps);
    int s, c0, s0, c1, s1;
    gaps = 0;
    for (int k = 0; k < cnt; k++) begin
      while (gaps < 2000 && int'($urandom_range(99)) < gap_pct) begin
        bus.sample_valid = 1'b0;
        drive(rnd18(), rnd18(), rnd18(), rnd18(), rnd18());
        step();
        gaps++;
      end
      pick(mode, s, c0, s0, c1, s1);
      bus.sample_valid = 1'b1;
      drive(s, c0, s0, c1, s1);
      m_re0 += scaled(s, c0);
      m_im0 -= scaled(s, s0);
      m_re1 += scaled(s, c1);
      m_im1 -= scaled(s, s1);
      step();
    end
    bus.sample_valid = 1'b0;
  endtask

  // Called just after the edge that accepted the Nth sample.
  task automatic finish_frame(input string tag);
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    cyc_done = cyc;
    check({tag, "_latency"}, 64'(lat), 64'(4));
    check({tag, "_busy_low"}, 64'(bus.busy), 64'(0));
    check({tag, "_pow0"}, {28'd0, bus.pow0}, 64'(bin_pow(m_re0, m_im0)));
    check({tag, "_pow1"}, {28'd0, bus.pow1}, 64'(bin_pow(m_re1, m_im1)));
    step();
    check({tag, "_single_pulse"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    int gaps, ov_before, s, c0, s0, c1, s1;
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    drive(0, 0, 0, 0, 0);
    RST = 1'b1;
    step(); step();
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_pow0", {28'd0, bus.pow0}, 64'(0));
    check("reset_pow1", {28'd0, bus.pow1}, 64'(0));
    RST = 1'b0;
    step();

    // Constant half-scale sample against near-unity cosine.
    start_frame();
    feed(0, N, 0, gaps);
    finish_frame("dc_cos");
    check("dc_cos_pow0_const", {28'd0, bus.pow0}, 64'h0_FFFE_0001);
    check("dc_cos_period", 64'(cyc_done - cyc_start), 64'(N + 9));

    // Negative sample with sine: floor makes each product -0x10000.
    start_frame();
    feed(1, N, 0, gaps);
    finish_frame("neg_sin");
    check("neg_sin_pow0_const", {28'd0, bus.pow0}, 64'h1_0000_0000);

    // 50% gaps: same result, out_valid later by exactly the gap count.
    start_frame();
    feed(0, N, 50, gaps);
    finish_frame("gappy");
    check("gappy_pow0_const", {28'd0, bus.pow0}, 64'h0_FFFE_0001);
    check("gappy_period", 64'(cyc_done - cyc_start), 64'(N + 9 + gaps));

    // Near-full-scale bin 1.
    start_frame();
    feed(2, N, 0, gaps);
    finish_frame("full_bin1");
    check("full_bin1_pow1_const", {28'd0, bus.pow1}, 64'h3_FFF8_0004);

    // Random frames.
    for (int f = 0; f < 3; f++) begin
      start_frame();
      feed(3, N, 20, gaps);
      finish_frame("random");
    end

    // Abort at sample 60, then a clean frame.
    ov_before = ov_seen;
    start_frame();
    feed(3, 60, 0, gaps);
    start_frame();
    feed(0, N, 0, gaps);
    finish_frame("after_abort");
    check("after_abort_pow0_const", {28'd0, bus.pow0}, 64'h0_FFFE_0001);
    check("abort_pulse_count", 64'(ov_seen - ov_before), 64'(1));

    // START coincident with the Nth sample discards the frame.
    ov_before = ov_seen;
    start_frame();
    feed(3, N - 1, 0, gaps);
    pick(3, s, c0, s0, c1, s1);
    bus.sample_valid = 1'b1;
    drive(s, c0, s0, c1, s1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    check("coincident_no_pulse", 64'(ov_seen - ov_before), 64'(0));
    check("coincident_busy", 64'(bus.busy), 64'(1));
    m_re0 = 0; m_im0 = 0; m_re1 = 0; m_im1 = 0;
    feed(3, N, 0, gaps);
    finish_frame("after_coincident");

    // RST mid-frame, then samples without START are ignored.
    ov_before = ov_seen;
    start_frame();
    feed(3, 100, 0, gaps);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_pow0", {28'd0, bus.pow0}, 64'(0));
    check("rst_pow1", {28'd0, bus.pow1}, 64'(0));
    feed(3, N + 10, 0, gaps);
    for (int k = 0; k < 8; k++) step();
    check("rst_ignored_busy", 64'(bus.busy), 64'(0));
    check("rst_ignored_pulse", 64'(ov_seen - ov_before), 64'(0));
    check("rst_ignored_pow0", {28'd0, bus.pow0}, 64'(0));

    // Saturation of a shifted accumulator beyond the Q1.17 range, and the -1*-1 wrap.
    check("sat_pos", {46'd0, sat_data(32'sd131072)}, {46'd0, 18'h1FFFF});
    check("sat_neg", {46'd0, sat_data(-32'sd131073)}, {46'd0, 18'h20000});
    check("sat_pass", {46'd0, sat_data(32'sd131070)}, {46'd0, 18'h1FFFE});
    check("wrap_min_sq", {46'd0, scale_prod(36'sh4_0000_0000)}, 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dft_bin_accum.md
# dft_bin_accum

Downstream consumer of the two-bin phasor NCO in the spectrogram datapath. Each cycle it multiplies one 18-bit audio sample by the NCO's rotating phasors (cos0/sin0 for bin 0, cos1/sin1 for bin 1) and accumulates the complex products over an N-sample frame. At frame end it computes |X|² for both bins and presents them with a one-cycle valid pulse, ready to be written into the spectrogram line buffer at the current v_pos.

## Interface
- N, 128: samples per frame; power of two, 2..1024; LOG2N = clog2(N)
- CK  in  1  clock; all logic rises on posedge CK
- RST  in  1  synchronous, active-high reset
- START  in  1  frame start; the same pulse that drives the NCO's START
- sample_valid  in  1  sample and phasors valid this cycle
- sample  in  18  signed Q1.17 audio sample
- cos0, sin0, cos1, sin1  in  18 each  signed Q1.17 phasors from the NCO, aligned with sample
- busy  out  1  high from START until out_valid
- out_valid  out  1  one-cycle pulse; pow0/pow1 are new
- pow0, pow1  out  36 each  unsigned bin power, held until the next out_valid

## Operation
- Product format: p = a*b is 36-bit signed; scaled product = {p[35], p[33:17]}, which floors toward −∞.
  - −0x20000 × −0x20000 yields 0. This wrap is accepted and documented; it is not corrected.
- Lane products:
  - re0 += s·cos0, im0 −= s·sin0
  - re1 += s·cos1, im1 −= s·sin1
- Accumulators are ACC_W = 18 + LOG2N bits signed, so they cannot overflow over N products.
- Power: each accumulator is arithmetic-shifted right by LOG2N, then saturated to the range [−0x20000, 0x1FFFF]. The result is squared (36-bit), and pow = re² + im² (fits in 36-bit unsigned).
- FSM states: IDLE, ACCUM, DRAIN, SQ0, SQ1, SQ2.
  - IDLE: START → ACCUM; clears accumulators, sample count and product registers. sample_valid is ignored in IDLE.
  - ACCUM: each sample_valid registers the four products (stage 1) and increments count. On the Nth accepted sample → DRAIN.
  - Stage 2 adds the registered products into the accumulators one cycle after stage 1.
  - DRAIN: last products are accumulated → SQ0.
  - SQ0: register bin-0 squares → SQ1.
  - SQ1: pow0 ← sum; register bin-1 squares → SQ2.
  - SQ2: pow1 ← sum; out_valid ← 1 next cycle → IDLE.
- START in any non-IDLE state aborts the frame. The accumulators clear, the state goes to ACCUM, the partial frame is discarded, and no out_valid is produced for it.
- START coincident with the Nth sample: START wins and the frame is discarded.
- The upstream driver holds sample_valid low during the NCO's 5-cycle preload after START. This block does not count those cycles.

## Timing
- Reset values:
  - state IDLE; busy 0; out_valid 0; pow0 = pow1 = 0
  - accumulators, product registers and count = 0
- RST mid-frame returns everything to the reset values on the next edge. No output is produced.
- busy rises on the edge that samples START and falls on the edge that raises out_valid.
- Latency: with edge e0 accepting the Nth sample, out_valid is high for the cycle following edge e0+4. pow0 and pow1 update on that same edge.
- Throughput: one sample per cycle. Gaps in sample_valid stall the count only.
- Minimum frame period is N + 4 cycles plus the START/preload cycles.

## Structure
- Shared package spectro_pkg:
  - DATA_W = 18, FRAC = 17
  - scaled-product function (sign bit + [33:17])
  - saturate-to-18 function
  - the NCO reuses these.
- Sub-module dft_mac_lane: one complex multiply-accumulate lane (sample × cos/sin, two ACC_W accumulators, clear and enable). Instantiated twice.
- The squaring step shares one pair of multipliers across SQ0/SQ1, controlled by the top-level FSM.

## Test plan
- N=128, sample=0x10000, cos0=0x1FFFF, sin0=0 constant for 128 valid cycles → pow0 = 0xFFFE0001, out_valid at e0+4, one pulse only.
- sample=−0x10000, sin0=0x1FFFF, cos0=0 → im0 = +0x10000 after shift; pow0 = 0x100000000 (checks floor asymmetry).
- sample_valid toggled 50%, same data as the first case → identical pow0, and out_valid delayed by exactly the number of gap cycles.
- START reissued at sample 60 → no out_valid for the aborted frame. The next full frame gives the first-case result, with no residue from the aborted frame.
- RST asserted at sample 100 → all outputs 0 and busy 0 next cycle. Samples after RST without START are ignored.
- sample=0x1FFFF, cos1=0x1FFFF, N=128 → re1 shift = 0x1FFFE, not saturated; pow1 = 0x3FFF80004. Also force an accumulator to +0x20000 after the shift and check it saturates to 0x1FFFF.
